mem_bus_arbiter: RTL



---
 rtl/nes_cpu_pkg.sv | 23 ++
 rtl/mem_rd_tag_pipe.sv | 48 ++++
 rtl/mem_bus_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/nes_cpu_pkg.sv
// Shared definitions for the NES CPU memory subsystem.
//   owner_e     : identifies which requester owns a bus cycle / read return
//   arb_state_e : mem_bus_arbiter FSM states
//   NES_ADDR_W / NES_DATA_W : CPU bus widths
package nes_cpu_pkg;

  localparam int unsigned NES_ADDR_W = 16;
  localparam int unsigned NES_DATA_W = 8;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_FETCH,
    OWN_EXEC,
    OWN_DMA
  } owner_e;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_EXEC_LOCK,
    ARB_DMA
  } arb_state_e;

endpackage

// File: rtl/mem_rd_tag_pipe.sv
// Owner-tag delay line for bus reads.
//   clk, rst          : clock, asynchronous active-high reset
//   issue_tag         : owner of a read granted this cycle (OWN_NONE otherwise)
//   mem_rdata         : bus read data, valid the cycle after a read bus cycle
//   f/e/d_rvalid      : read return strobe per requester
//   f/e/d_rdata       : read data per requester (zero when not valid)
// Tag stage 1 tracks the bus cycle in flight, stage 2 tracks the cycle whose
// data is on mem_rdata now, so returns appear two cycles after the grant.
module mem_rd_tag_pipe
  import nes_cpu_pkg::*;
#(
  parameter int unsigned DATA_W = NES_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  owner_e            issue_tag,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  output logic              e_rvalid,
  output logic [DATA_W-1:0] e_rdata,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata
);

  owner_e bus_tag;
  owner_e ret_tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_tag <= OWN_NONE;
      ret_tag <= OWN_NONE;
    end else begin
      bus_tag <= issue_tag;
      ret_tag <= bus_tag;
    end
  end

  always_comb begin
    f_rvalid = (ret_tag == OWN_FETCH);
    e_rvalid = (ret_tag == OWN_EXEC);
    d_rvalid = (ret_tag == OWN_DMA);
    f_rdata  = f_rvalid ? mem_rdata : '0;
    e_rdata  = e_rvalid ? mem_rdata : '0;
    d_rdata  = d_rvalid ? mem_rdata : '0;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-port CPU bus arbiter shared by fetch, execute and OAM DMA.
//   clk, rst                       : clock, asynchronous active-high reset
//   f_req/f_addr -> f_gnt          : fetch read request / combinational grant
//   e_req/e_rw_n/e_addr/e_wdata    : execute access; e_lock reserves the bus
//   d_req/d_rw_n/d_addr/d_wdata    : DMA access, d_req held for whole transfer
//   *_rvalid/*_rdata               : tagged read returns, two cycles after grant
//   mem_en/mem_rw_n/mem_addr/mem_wdata/mem_rdata : registered bus interface
//   halt_fetch                     : fetch is requesting but not granted
// Priority DMA > execute > fetch, except that fetch beats execute once it has
// been denied STARVE_MAX times in a row. EXEC_LOCK and DMA hold the bus for
// their owner until e_lock / d_req drop; arbitration resumes that same cycle.
module mem_bus_arbiter
  import nes_cpu_pkg::*;
#(
  parameter int unsigned ADDR_W     = NES_ADDR_W,
  parameter int unsigned DATA_W     = NES_DATA_W,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              e_req,
  input  logic              e_rw_n,
  input  logic [ADDR_W-1:0] e_addr,
  input  logic [DATA_W-1:0] e_wdata,
  input  logic              e_lock,
  output logic              e_gnt,
  output logic              e_rvalid,
  output logic [DATA_W-1:0] e_rdata,
  input  logic              d_req,
  input  logic              d_rw_n,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_rw_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              halt_fetch
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arb_state_e state;
  logic [3:0] starve_cnt;

  logic   lock_hold;
  logic   dma_hold;
  logic   free_arb;
  owner_e gnt_owner;
  owner_e rd_tag;

  // lock_hold/dma_hold: the reserving requester still asserts its hold signal.
  // Once it drops, the cycle is arbitrated as if already back in IDLE.
  always_comb begin
    lock_hold = (state == ARB_EXEC_LOCK) && e_lock;
    dma_hold  = (state == ARB_DMA) && d_req;
    free_arb  = !lock_hold && !dma_hold;
    f_gnt     = 1'b0;
    e_gnt     = 1'b0;
    d_gnt     = 1'b0;
    if (lock_hold)
      e_gnt = e_req;
    else if (d_req)
      d_gnt = 1'b1;
    else if (f_req && (starve_cnt == STARVE_LIM))
      f_gnt = 1'b1;
    else if (e_req)
      e_gnt = 1'b1;
    else if (f_req)
      f_gnt = 1'b1;
  end

  always_comb begin
    gnt_owner = OWN_NONE;
    rd_tag    = OWN_NONE;
    if (d_gnt) begin
      gnt_owner = OWN_DMA;
      if (d_rw_n) rd_tag = OWN_DMA;
    end else if (e_gnt) begin
      gnt_owner = OWN_EXEC;
      if (e_rw_n) rd_tag = OWN_EXEC;
    end else if (f_gnt) begin
      gnt_owner = OWN_FETCH;
      rd_tag    = OWN_FETCH;
    end
  end

  assign halt_fetch = f_req && !f_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB_IDLE;
      starve_cnt <= '0;
      mem_en     <= 1'b0;
      mem_rw_n   <= 1'b1;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      mem_en <= (gnt_owner != OWN_NONE);
      case (gnt_owner)
        OWN_FETCH: begin
          mem_rw_n <= 1'b1;
          mem_addr <= f_addr;
        end
        OWN_EXEC: begin
          mem_rw_n  <= e_rw_n;
          mem_addr  <= e_addr;
          mem_wdata <= e_wdata;
        end
        OWN_DMA: begin
          mem_rw_n  <= d_rw_n;
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
        end
        default: mem_rw_n <= 1'b1;
      endcase

      if (free_arb) begin
        if (d_gnt)
          state <= ARB_DMA;
        else if (e_gnt && e_lock)
          state <= ARB_EXEC_LOCK;
        else
          state <= ARB_IDLE;
      end

      if (f_gnt || !f_req)
        starve_cnt <= '0;
      else if (free_arb && (starve_cnt != STARVE_LIM))
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

  mem_rd_tag_pipe #(
    .DATA_W(DATA_W)
  ) u_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .issue_tag(rd_tag),
    .mem_rdata(mem_rdata),
    .f_rvalid (f_rvalid),
    .f_rdata  (f_rdata),
    .e_rvalid (e_rvalid),
    .e_rdata  (e_rdata),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata)
  );

endmodule
